alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the 16-bit combinational ALU interface. Accepts one instruction
//  at a time over a valid/ready handshake and reads operands from a 4x16 register file.
//  Drives A/B/Op to the ALU, waits ALU_SETTLE cycles, then captures Y and the C/V/N/Z flags.
//  Writes Y back to the destination register and returns the result over a valid/ready port.
// PARAMETERS
//  DATA_W      16  datapath width; must match the ALU operand width
//  NREG        4   register file depth (index width 2, fixed)
//  ALU_SETTLE  1   cycles operands are held on the ALU before Y and flags are sampled (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  instr_valid  in   1       instruction offered
//  instr_ready  out  1       controller can accept an instruction
//  instr        in   24      [23:20] op, [19:18] rd, [17:16] ra, [15:0] imm; rb = imm[1:0]
//  alu_a        out  DATA_W  operand A to the ALU (registered)
//  alu_b        out  DATA_W  operand B to the ALU (registered)
//  alu_op       out  4       ALU opcode (registered)
//  alu_y        in   DATA_W  ALU result
//  alu_c/v/n/z  in   1 each  ALU carry, overflow, negative, zero
//  res_valid    out  1       result available
//  res_ready    in   1       consumer accepts result
//  res_data     out  DATA_W  value written to rd (0 on error)
//  res_flags    out  4       {C,V,N,Z} flag register after this instruction
//  res_err      out  1       instruction was illegal
// BEHAVIOUR
//  Reset: while rst=1 at an edge, FSM->IDLE and regs r0..r3, flags, alu_a/b/op, res_data,
//   res_flags, res_err all go to 0. res_valid=0; instr_ready=0 while rst is high.
//   Reset wins over any in-flight instruction; a pending result is dropped and never presented.
//  FSM states: IDLE, EXEC, RESP.
//  IDLE: instr_ready=1. An instruction is accepted at edge T when instr_valid & instr_ready.
//  Legal ALU ops: 0000 INC, 0001 DEC, 0010 SUB, 0011 ADD, 0111 LAND, 1000 LOR, 1001 AND,
//   1010 OR, 1011 XNOR. At edge T: alu_a<=r[ra], alu_b<=r[rb], alu_op<=op; go to EXEC.
//  EXEC: lasts exactly ALU_SETTLE cycles; alu_a/b/op are held stable throughout.
//   On the last EXEC edge: r[rd]<=alu_y, res_data<=alu_y, then update flags:
//     N and Z always take alu_n and alu_z.
//     C and V take alu_c/alu_v only for ops 0000-0011; for other ops they keep prior values.
//   res_err<=0; go to RESP. First res_valid cycle is T+1+ALU_SETTLE.
//  1111 LDI: at edge T r[rd]<=imm and res_data<=imm; flags are unchanged; no ALU issue.
//   Go to RESP (res_valid at T+1).
//  Illegal ops 0100,0101,0110,1100,1101,1110: no write, flags unchanged, res_data<=0,
//   res_err<=1; go to RESP at T+1.
//  RESP: res_valid=1 and instr_ready=0. res_data, res_flags and res_err are stable until
//   res_valid & res_ready at an edge, then go to IDLE. There is no bypass: the next accept
//   happens no earlier than the cycle after the result handshake.
//  rd may equal ra or rb; operands are sampled at accept, so the old value is used.
//  Arithmetic wraps modulo 2^DATA_W (ALU behaviour); this block performs no arithmetic of its own.
//  alu_* outputs keep their last values outside EXEC.
// TESTING
//  1 LDI r1=7FFF, LDI r2=0001, ADD r3=r1,r2 -> res_data 8000, {C,V,N,Z}=0110, valid at T+2.
//  2 LDI r0=0000, DEC r0=r0 -> res_data FFFF, N=1, Z=0; C/V equal to ALU outputs; r0 reads FFFF.
//  3 op 0100 -> res_err=1, res_data 0000, valid at T+1; flags and all regs unchanged.
//  4 ADD result with res_ready=0 for 5 cycles -> res_valid, res_data, res_flags stable;
//    instr_ready=0 and an offered instr is not accepted until the cycle after the handshake.
//  5 rst=1 during EXEC -> next cycle IDLE, res_valid never asserts;
//    a following ADD r0=r1,r2 returns 0000 with Z=1.
//  6 After an ADD with C=1, LDI r1=5, LDI r2=0, LAND -> res_data 0000, Z=1, C stays 1;
//    with ALU_SETTLE=3, valid at T+4.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a 16-bit combinational ALU: accepts one instruction at a time,
// reads a 4-entry register file, drives the ALU, writes back and returns the result.
module alu_issue_ctrl #(
    parameter int DATA_W     = 16,
    parameter int NREG       = 4,
    parameter int ALU_SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [23:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [3:0]        res_flags,
    output logic              res_err
);

    localparam int CNT_W = (ALU_SETTLE > 1) ? $clog2(ALU_SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rf_q [NREG];
    logic [DATA_W-1:0]  rf_d [NREG];
    logic [1:0]         rd_q, rd_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic [3:0]         flags_q, flags_d;
    logic               res_err_q, res_err_d;

    logic [3:0]         op;
    logic [1:0]         rd, ra, rb;
    logic [15:0]        imm;
    logic               op_alu, op_ldi, accept, exec_last;

    assign op  = instr[23:20];
    assign rd  = instr[19:18];
    assign ra  = instr[17:16];
    assign imm = instr[15:0];
    assign rb  = imm[1:0];

    always_comb begin
        op_alu = 1'b0;
        unique case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: op_alu = 1'b1;
            default: op_alu = 1'b0;
        endcase
    end

    assign op_ldi    = (op == 4'hF);
    assign accept    = instr_valid & instr_ready;
    assign exec_last = (state_q == EXEC) && (cnt_q == CNT_W'(ALU_SETTLE - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)    state_d = op_alu ? EXEC : RESP;
            EXEC: if (exec_last) state_d = RESP;
            RESP: if (res_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == IDLE) && !rst;
        res_valid   = (state_q == RESP) && !rst;
    end

    // Operands are latched at accept so rd may alias ra/rb without a hazard.
    always_comb begin
        cnt_d      = cnt_q;
        rf_d       = rf_q;
        rd_d       = rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
        flags_d    = flags_q;
        res_err_d  = res_err_q;
        if (state_q == IDLE && accept) begin
            cnt_d = '0;
            rd_d  = rd;
            if (op_alu) begin
                alu_a_d  = rf_q[ra];
                alu_b_d  = rf_q[rb];
                alu_op_d = op;
            end else if (op_ldi) begin
                rf_d[rd]   = DATA_W'(imm);
                res_data_d = DATA_W'(imm);
                res_err_d  = 1'b0;
            end else begin
                res_data_d = '0;
                res_err_d  = 1'b1;
            end
        end else if (state_q == EXEC) begin
            cnt_d = cnt_q + 1'b1;
            if (exec_last) begin
                rf_d[rd_q] = alu_y;
                res_data_d = alu_y;
                res_err_d  = 1'b0;
                flags_d[1] = alu_n;
                flags_d[0] = alu_z;
                // Carry/overflow only belong to the arithmetic opcodes.
                if (alu_op_q[3:2] == 2'b00) begin
                    flags_d[3] = alu_c;
                    flags_d[2] = alu_v;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rd_q       <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_data_q <= '0;
            flags_q    <= '0;
            res_err_q  <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_data_q <= res_data_d;
            flags_q    <= flags_d;
            res_err_q  <= res_err_d;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_data  = res_data_q;
    assign res_flags = flags_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_SETTLE 1 and 3), each driven by a
// behavioural ALU, with table vectors checked through an expectation queue.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [15:0] y;
        logic        c, v, n, z;
    } alu_res_t;

    typedef struct {
        int unsigned inst;
        logic [23:0] ins;
        int unsigned stall;
        bit          offer;
        bit          rst_before;
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst         [2];
    logic        instr_valid [2];
    logic        instr_ready [2];
    logic [23:0] instr       [2];
    logic [15:0] alu_a       [2];
    logic [15:0] alu_b       [2];
    logic [3:0]  alu_op      [2];
    alu_res_t    alu_r       [2];
    logic        res_valid   [2];
    logic        res_ready   [2];
    logic [15:0] res_data    [2];
    logic [3:0]  res_flags   [2];
    logic        res_err     [2];

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    exp_t sb[$];

    function automatic alu_res_t alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        alu_res_t    r;
        logic [16:0] w;
        r = '0;
        w = '0;
        case (op)
            4'h0: begin w = {1'b0, a} + 17'd1;        r.v = (a == 16'h7FFF); end
            4'h1: begin w = {1'b0, a} - 17'd1;        r.v = (a == 16'h8000); end
            4'h2: begin w = {1'b0, a} - {1'b0, b};    r.v = (a[15] != b[15]) && (w[15] != a[15]); end
            4'h3: begin w = {1'b0, a} + {1'b0, b};    r.v = (a[15] == b[15]) && (w[15] != a[15]); end
            4'h7: w = {16'b0, (a != 16'h0) && (b != 16'h0)};
            4'h8: w = {16'b0, (a != 16'h0) || (b != 16'h0)};
            4'h9: w = {1'b0, a & b};
            4'hA: w = {1'b0, a | b};
            4'hB: w = {1'b0, ~(a ^ b)};
            default: w = '0;
        endcase
        r.y = w[15:0];
        r.c = (op <= 4'h3) ? w[16] : 1'b0;
        r.n = w[15];
        r.z = (w[15:0] == 16'h0);
        return r;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            alu_issue_ctrl #(.DATA_W(16), .NREG(4), .ALU_SETTLE(g == 0 ? 1 : 3)) u_dut (
                .clk         (clk),
                .rst         (rst[g]),
                .instr_valid (instr_valid[g]),
                .instr_ready (instr_ready[g]),
                .instr       (instr[g]),
                .alu_a       (alu_a[g]),
                .alu_b       (alu_b[g]),
                .alu_op      (alu_op[g]),
                .alu_y       (alu_r[g].y),
                .alu_c       (alu_r[g].c),
                .alu_v       (alu_r[g].v),
                .alu_n       (alu_r[g].n),
                .alu_z       (alu_r[g].z),
                .res_valid   (res_valid[g]),
                .res_ready   (res_ready[g]),
                .res_data    (res_data[g]),
                .res_flags   (res_flags[g]),
                .res_err     (res_err[g])
            );
            always_comb alu_r[g] = alu_fn(alu_op[g], alu_a[g], alu_b[g]);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input int unsigned inst, input logic [3:0] op, input logic [1:0] rd,
                                 input logic [1:0] ra, input logic [15:0] imm, input int unsigned stall,
                                 input bit offer, input bit rstb, input logic [15:0] data,
                                 input logic [3:0] flags, input logic err, input int unsigned lat);
        vec_t v;
        v.inst = inst; v.ins = {op, rd, ra, imm}; v.stall = stall; v.offer = offer;
        v.rst_before = rstb; v.data = data; v.flags = flags; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic do_reset(input int unsigned k);
        rst[k] = 1'b1;
        tick();
        check("rst_instr_ready", instr_ready[k], 0);
        check("rst_res_valid", res_valid[k], 0);
        tick();
        rst[k] = 1'b0;
        #1;
        check("rst_res_data", res_data[k], 0);
        check("rst_res_flags", res_flags[k], 0);
        check("rst_res_err", res_err[k], 0);
        check("rst_alu_a", alu_a[k], 0);
        check("rst_alu_b", alu_b[k], 0);
        check("rst_alu_op", alu_op[k], 0);
        check("idle_instr_ready", instr_ready[k], 1);
    endtask

    // Reset lands while an ADD is in EXEC; its result must never appear.
    task automatic reset_mid_exec(input int unsigned k);
        bit seen;
        instr[k] = {4'h3, 2'd0, 2'd1, 16'h0002};
        instr_valid[k] = 1'b1;
        check("rstseq_ready", instr_ready[k], 1);
        tick();
        instr_valid[k] = 1'b0;
        check("rstseq_in_exec", res_valid[k], 0);
        tick();
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
        #1;
        check("rstseq_idle", instr_ready[k], 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid[k]) seen = 1;
            tick();
        end
        check("rstseq_no_valid", seen, 0);
        check("rstseq_flags", res_flags[k], 0);
    endtask

    task automatic issue(input int idx);
        vec_t        v;
        exp_t        e;
        int unsigned k, n, w;
        bit          acc, rdy;
        v = tbl[idx];
        k = v.inst;
        instr[k] = v.ins;
        instr_valid[k] = 1'b1;
        n = 0;
        acc = 0;
        while (!acc && n < 20) begin
            rdy = instr_ready[k];
            tick();
            n++;
            if (rdy) acc = 1;
        end
        instr_valid[k] = 1'b0;
        if (!acc) begin
            check("accept_timeout", 0, 1);
            return;
        end
        sb.push_back('{v.data, v.flags, v.err});
        w = 0;
        while (!res_valid[k] && w < 20) begin
            if (v.lat > 1) check("alu_op_hold", alu_op[k], v.ins[23:20]);
            tick();
            w++;
        end
        if (!res_valid[k]) begin
            check("result_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        check("latency", w + 1, v.lat);
        if (v.offer && idx + 1 < tbl.size()) begin
            instr[k] = tbl[idx + 1].ins;
            instr_valid[k] = 1'b1;
        end
        for (int unsigned s = 0; s < v.stall; s++) begin
            check("stall_instr_ready", instr_ready[k], 0);
            check("stall_res_valid", res_valid[k], 1);
            check("stall_res_data", res_data[k], v.data);
            check("stall_res_flags", res_flags[k], v.flags);
            tick();
        end
        e = sb.pop_front();
        check("res_data", res_data[k], e.data);
        check("res_flags", res_flags[k], e.flags);
        check("res_err", res_err[k], e.err);
        res_ready[k] = 1'b1;
        tick();
        res_ready[k] = 1'b0;
        check("post_hs_valid", res_valid[k], 0);
        check("post_hs_ready", instr_ready[k], 1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; instr_valid[k] = 1'b0; instr[k] = '0; res_ready[k] = 1'b0;
        end

        // ALU_SETTLE = 1
        tbl.push_back(mkv(0, 4'hF, 1, 0, 16'h7FFF, 0, 0, 0, 16'h7FFF, 4'b0000, 0, 1));
        tbl.push_back(mkv(0, 4'hF, 2, 0, 16'h0001, 0, 0, 0, 16'h0001, 4'b0000, 0, 1));
        tbl.push_back(mkv(0, 4'h3, 3, 1, 16'h0002, 0, 0, 0, 16'h8000, 4'b0110, 0, 2));
        tbl.push_back(mkv(0, 4'hF, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'b0110, 0, 1));
        tbl.push_back(mkv(0, 4'h1, 0, 0, 16'h0000, 0, 0, 0, 16'hFFFF, 4'b1010, 0, 2));
        tbl.push_back(mkv(0, 4'hA, 0, 0, 16'h0000, 0, 0, 0, 16'hFFFF, 4'b1010, 0, 2));
        tbl.push_back(mkv(0, 4'h4, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'b1010, 1, 1));
        tbl.push_back(mkv(0, 4'hA, 1, 1, 16'h0001, 0, 0, 0, 16'h7FFF, 4'b1000, 0, 2));
        tbl.push_back(mkv(0, 4'h2, 2, 3, 16'h0001, 0, 0, 0, 16'h0001, 4'b0100, 0, 2));
        tbl.push_back(mkv(0, 4'hB, 2, 2, 16'h0002, 0, 0, 0, 16'hFFFF, 4'b0110, 0, 2));
        tbl.push_back(mkv(0, 4'h3, 3, 3, 16'h0001, 5, 1, 0, 16'hFFFF, 4'b0010, 0, 2));
        tbl.push_back(mkv(0, 4'hF, 3, 0, 16'h1234, 0, 0, 0, 16'h1234, 4'b0010, 0, 1));
        tbl.push_back(mkv(0, 4'h0, 1, 1, 16'h0000, 0, 0, 0, 16'h8000, 4'b0110, 0, 2));
        tbl.push_back(mkv(0, 4'h9, 0, 3, 16'h0001, 0, 0, 0, 16'h0000, 4'b0101, 0, 2));
        tbl.push_back(mkv(0, 4'h7, 0, 3, 16'h0001, 0, 0, 0, 16'h0001, 4'b0100, 0, 2));
        tbl.push_back(mkv(0, 4'hE, 2, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'b0100, 1, 1));
        tbl.push_back(mkv(0, 4'h8, 1, 0, 16'h0002, 0, 0, 0, 16'h0001, 4'b0100, 0, 2));
        // ALU_SETTLE = 3
        tbl.push_back(mkv(1, 4'hF, 1, 0, 16'hFFFF, 0, 0, 0, 16'hFFFF, 4'b0000, 0, 1));
        tbl.push_back(mkv(1, 4'hF, 2, 0, 16'h0001, 0, 0, 0, 16'h0001, 4'b0000, 0, 1));
        tbl.push_back(mkv(1, 4'h3, 3, 1, 16'h0002, 0, 0, 0, 16'h0000, 4'b1001, 0, 4));
        tbl.push_back(mkv(1, 4'hF, 1, 0, 16'h0005, 0, 0, 0, 16'h0005, 4'b1001, 0, 1));
        tbl.push_back(mkv(1, 4'hF, 2, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'b1001, 0, 1));
        tbl.push_back(mkv(1, 4'h7, 0, 1, 16'h0002, 2, 0, 0, 16'h0000, 4'b1001, 0, 4));
        tbl.push_back(mkv(1, 4'h3, 0, 1, 16'h0002, 0, 0, 1, 16'h0000, 4'b0001, 0, 4));
        tbl.push_back(mkv(1, 4'hC, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001, 1, 1));

        do_reset(0);
        do_reset(1);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) reset_mid_exec(tbl[i].inst);
            issue(i);
        end
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
